// File: rtl/pipeline_skid_stage.sv
// Pipeline boundary register with a valid/ready handshake, a two-entry skid buffer,
// a flush port that inserts bubbles, and a saturating downstream-stall counter.
module pipeline_skid_stage #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 43,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding doubles as the beat count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic accept, consume;
  logic load_main_in, load_skid_in, load_main_skid;

  // Handshake: a beat moves on an edge where valid and ready are both high.
  // in_ready comes only from registered state and rst, never from out_ready.
  assign in_ready  = ~rst & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          load_skid_in = 1'b1;
          state_nxt    = TWO;
        end else if (consume) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A beat offered during flush is squashed, so nothing is captured.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_skid_in   = 1'b0;
      load_main_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid_in) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Self-checking bench for pipeline_skid_stage: queue-based scoreboard plus
// scenario tasks for reset, streaming, backpressure, flush, overlap and saturation.
module tb_pipeline_skid_stage;

  localparam int CTRL_W = 6;
  localparam int DATA_W = 43;
  localparam int CNT_W  = 4;
  localparam int W      = CTRL_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipeline_skid_stage #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_stall = '0;
  bit               sb_en = 1'b0;

  // Checks outputs against the model, then advances the model through one edge.
  task automatic tick();
    logic m_ready, acc, cons;
    #2;
    if (sb_en) begin
      m_ready = !rst && (exp_q.size() < 2);
      checks++;
      if (in_ready !== m_ready) begin
        errors++;
        $display("FAIL in_ready got %0b exp %0b t=%0t", in_ready, m_ready, $time);
      end
      checks++;
      if (occupancy !== 2'(exp_q.size())) begin
        errors++;
        $display("FAIL occupancy got %0d exp %0d t=%0t", occupancy, exp_q.size(), $time);
      end
      checks++;
      if (out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid got %0b exp %0b t=%0t", out_valid, exp_q.size() != 0, $time);
      end
      checks++;
      if (stall_cnt !== exp_stall) begin
        errors++;
        $display("FAIL stall_cnt got %0d exp %0d t=%0t", stall_cnt, exp_stall, $time);
      end
      checks++;
      if (exp_q.size() == 0) begin
        if (out_ctrl !== '0) begin
          errors++;
          $display("FAIL idle_ctrl got %0h exp 0 t=%0t", out_ctrl, $time);
        end
      end else if ({out_ctrl, out_data} !== exp_q[0]) begin
        errors++;
        $display("FAIL beat got %0h/%0h exp %0h/%0h t=%0t", out_ctrl, out_data,
                 exp_q[0][W-1:DATA_W], exp_q[0][DATA_W-1:0], $time);
      end
      acc  = in_valid && m_ready && !flush;
      cons = !rst && (exp_q.size() != 0) && out_ready;
      if (rst) begin
        exp_q.delete();
        exp_stall = '0;
      end else begin
        if (exp_q.size() != 0 && !out_ready && exp_stall != {CNT_W{1'b1}})
          exp_stall = exp_stall + 1'b1;
        if (cons) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back({in_ctrl, in_data});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = CTRL_W'($urandom_range(1, 63));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, '0);
    flush = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 43'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 ||
          in_ready !== 1'b0 || out_data !== '0 || stall_cnt !== '0) begin
        errors++;
        $display("FAIL reset_hold got v=%0b c=%0h o=%0d r=%0b d=%0h s=%0d exp all 0",
                 out_valid, out_ctrl, occupancy, in_ready, out_data, stall_cnt);
      end
    end
    rst = 1'b0;
    drive(1'b0, '0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready got %0b exp 1", in_ready);
    end
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DATA_W'(i));
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || occupancy > 2'd1) begin
        errors++;
        $display("FAIL stream beat %0d got v=%0b d=%0d occ=%0d exp v=1 d=%0d occ<=1",
                 i, out_valid, out_data, occupancy, i);
      end
    end
    drive(1'b0, '0);
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    apply_reset();
    out_ready = 1'b0;
    drive(1'b1, 43'hA);
    tick();
    drive(1'b1, 43'hB);
    tick();
    drive(1'b1, 43'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 43'hA) begin
        errors++;
        $display("FAIL backpressure_hold got occ=%0d rdy=%0b d=%0h exp 2/0/a",
                 occupancy, in_ready, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (stall_cnt !== CNT_W'(4)) begin
      errors++;
      $display("FAIL backpressure_stall got %0d exp 4", stall_cnt);
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL backpressure_timeout in_ready got %0b exp 1", in_ready);
    end
    tick();
    drive(1'b0, '0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b0;
    drive(1'b1, 43'h1);
    tick();
    drive(1'b1, 43'h2);
    tick();
    flush = 1'b1;
    drive(1'b1, 43'hD);
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush got v=%0b c=%0h occ=%0d exp 0/0/0", out_valid, out_ctrl, occupancy);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b1;
    drive(1'b1, 43'h100);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, DATA_W'(43'h100 + i));
      tick();
      checks++;
      if (occupancy !== 2'd1 || out_data !== DATA_W'(43'h100 + i)) begin
        errors++;
        $display("FAIL overlap %0d got occ=%0d d=%0h exp 1/%0h", i, occupancy, out_data, 43'h100 + i);
      end
    end
    drive(1'b0, '0);
    tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    out_ready = 1'b0;
    drive(1'b1, 43'h77);
    tick();
    drive(1'b0, '0);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL saturate got %0d exp 15", stall_cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL saturate_flush got %0d exp 15", stall_cnt);
    end
    apply_reset();
    checks++;
    if (stall_cnt !== '0) begin
      errors++;
      $display("FAIL saturate_rst got %0d exp 0", stall_cnt);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), {11'($urandom), 32'($urandom)});
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0);
    @(posedge clk);
    #1;
    sb_en = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
